// File: rtl/obi_mem_pkg.sv
// rtl/obi_mem_pkg.sv - shared widths and types for the OBI memory responder
//
// Purpose: bus widths, the response payload carried through the latency
// pipe, and the outstanding-counter type (sized to hold 0..8).
// Configuration macro used by the bundle: OBI_MEM_ERR_EN.

package obi_mem_pkg;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;
  localparam int OBI_BE_W   = 4;

  // Largest MAX_OUTSTANDING the responder supports.
  localparam int OBI_MAX_OUTSTANDING_LIMIT = 8;

  // Must represent the value 8 itself, hence the +1.
  typedef logic [$clog2(OBI_MAX_OUTSTANDING_LIMIT + 1)-1:0] obi_mem_cnt_t;

  typedef struct packed {
    logic [OBI_DATA_W-1:0] rdata;
    logic                  err;
  } obi_mem_rsp_t;

  localparam int OBI_RSP_W = $bits(obi_mem_rsp_t);

endpackage

// File: rtl/obi_mem_rsp_pipe.sv
// rtl/obi_mem_rsp_pipe.sv - fixed-latency valid+payload delay line
//
// Purpose: delays a response by exactly LATENCY clock edges. A synchronous
// clear drops everything in flight.
// Ports:
//   clk_i    - clock
//   clr_i    - synchronous clear, active high
//   valid_i  - response enters the line this cycle
//   rsp_i    - response payload (packed obi_mem_rsp_t)
//   valid_o  - response leaves the line (LATENCY cycles after valid_i)
//   rsp_o    - payload matching valid_o; all zero when valid_o is low

module obi_mem_rsp_pipe
  import obi_mem_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 clr_i,
  input  logic                 valid_i,
  input  logic [OBI_RSP_W-1:0] rsp_i,
  output logic                 valid_o,
  output logic [OBI_RSP_W-1:0] rsp_o
);

  logic [LATENCY-1:0]   valid_q;
  logic [OBI_RSP_W-1:0] rsp_q [LATENCY];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        rsp_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      // Idle slots carry zeros so rsp_o is clean whenever valid_o is low.
      rsp_q[0]   <= valid_i ? rsp_i : '0;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        rsp_q[i]   <= rsp_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign rsp_o   = rsp_q[LATENCY-1];

endmodule

// File: rtl/obi_mem_responder.sv
// rtl/obi_mem_responder.sv - word-addressed OBI memory responder
//
// Purpose: grants OBI requests under an outstanding limit and a stall hook,
// performs byte-enabled reads/writes on an internal array and returns
// in-order responses LATENCY cycles after the grant cycle.
// Configuration macro: OBI_MEM_ERR_EN - when defined, addresses with any bit
// at or above log2(SIZE_BYTE) set are flagged with err_o and writes to them
// are dropped; when undefined, addresses wrap modulo SIZE_BYTE and err_o is 0.
// Ports:
//   clk_i, rst_i       - clock, synchronous active-high reset
//   req_i / gnt_o      - OBI request / grant (grant is combinational)
//   addr_i, we_i, be_i - byte address, write enable, byte enables
//   wdata_i            - write data
//   rvalid_o           - one-cycle response strobe, no back-pressure
//   rdata_o, err_o     - response data (0 for writes) and error flag
//   stall_i            - blocks new grants while high

module obi_mem_responder
  import obi_mem_pkg::*;
#(
  parameter int SIZE_BYTE       = 32768,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [OBI_ADDR_W-1:0] addr_i,
  input  logic                  we_i,
  input  logic [OBI_BE_W-1:0]   be_i,
  input  logic [OBI_DATA_W-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [OBI_DATA_W-1:0] rdata_o,
  output logic                  err_o,
  input  logic                  stall_i
);

  localparam int           AW      = $clog2(SIZE_BYTE);
  localparam int           WORDS   = SIZE_BYTE / 4;
  localparam obi_mem_cnt_t MAX_CNT = obi_mem_cnt_t'(MAX_OUTSTANDING);

  logic [OBI_DATA_W-1:0] mem_q [WORDS];

  logic [AW-3:0] word_idx;
  logic          addr_ok;
  logic          accept;
  logic          unused_addr;
  obi_mem_cnt_t  cnt_q, cnt_d;
  obi_mem_rsp_t  rsp_in, rsp_out;

  assign word_idx = addr_i[AW-1:2];

`ifdef OBI_MEM_ERR_EN
  localparam logic [OBI_ADDR_W-1:0] HI_MASK = ~(OBI_ADDR_W'(SIZE_BYTE - 1));
  assign addr_ok = (addr_i & HI_MASK) == '0;
`else
  assign addr_ok = 1'b1;
`endif

  // Byte-offset bits (and the upper bits in the wrapping build) are not decoded.
  assign unused_addr = ^addr_i;

  // A response retiring this cycle frees its slot for a grant in the same
  // cycle, so MAX_OUTSTANDING >= LATENCY sustains one transaction per cycle.
  assign gnt_o  = req_i & ~stall_i & ~rst_i & ((cnt_q < MAX_CNT) | rvalid_o);
  assign accept = req_i & gnt_o;

  // Combinational read: returns the word as it was before this edge's write.
  always_comb begin
    rsp_in       = '0;
    rsp_in.err   = ~addr_ok;
    if (!we_i && addr_ok) begin
      rsp_in.rdata = mem_q[word_idx];
    end
  end

  // Array has no reset: contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && addr_ok) begin
      for (int b = 0; b < OBI_BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !rvalid_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!accept && rvalid_o && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  obi_mem_rsp_pipe #(
    .LATENCY (LATENCY)
  ) u_rsp_pipe (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .valid_i (accept),
    .rsp_i   (rsp_in),
    .valid_o (rvalid_o),
    .rsp_o   (rsp_out)
  );

  assign rdata_o = rsp_out.rdata;

`ifdef OBI_MEM_ERR_EN
  assign err_o = rsp_out.err;
`else
  assign err_o = 1'b0;
`endif

endmodule
